// File: rtl/ram_mfa_ctrl.sv
// rtl/ram_mfa_ctrl.sv - big-endian byte-addressed RAM with MFA/MOC handshake and preload port
module ram_mfa_ctrl #(
    parameter int ADDR_WIDTH = 9,
    parameter int LATENCY    = 2,
    parameter int CNT_WIDTH  = 4
) (
    input  logic                  main_clk,
    input  logic                  reset,
    input  logic                  mfa,
    input  logic                  rw,
    input  logic [1:0]            mode,
    input  logic                  sext,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [31:0]           data_in,
    input  logic                  ld_en,
    input  logic [ADDR_WIDTH-1:0] ld_addr,
    input  logic [7:0]            ld_data,
    output logic [31:0]           data_out,
    output logic                  moc,
    output logic                  busy,
    output logic                  align_err
);

    localparam int                 DEPTH    = 2 ** ADDR_WIDTH;
    localparam logic [CNT_WIDTH-1:0] CNT_INIT = CNT_WIDTH'(LATENCY - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_DONE
    } state_t;

    state_t                state_q;
    logic [CNT_WIDTH-1:0]  cnt_q;
    logic                  rw_q;
    logic                  sext_q;
    logic [1:0]            mode_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [31:0]           wdata_q;
    logic [31:0]           dout_q;
    logic                  moc_q;
    logic                  busy_q;
    logic                  err_q;

    logic [7:0]            mem_q [0:DEPTH-1];

    logic                  aligned;
    logic                  complete;
    logic                  wr_commit;
    logic                  ld_fire;
    logic [ADDR_WIDTH-1:0] a0, a1, a2, a3;
    logic [7:0]            b0, b1, b2, b3;
    logic [31:0]           rdata_d;

    // Aligned accesses never cross a word boundary, so neighbour bytes are formed by
    // overwriting the low address bits instead of adding.
    assign a0 = addr_q;
    assign a1 = {addr_q[ADDR_WIDTH-1:1], 1'b1};
    assign a2 = {addr_q[ADDR_WIDTH-1:2], 2'b10};
    assign a3 = {addr_q[ADDR_WIDTH-1:2], 2'b11};

    assign b0 = mem_q[a0];
    assign b1 = mem_q[a1];
    assign b2 = mem_q[a2];
    assign b3 = mem_q[a3];

    always_comb begin
        aligned = 1'b0;
        case (mode_q)
            2'b00:   aligned = 1'b1;
            2'b01:   aligned = ~addr_q[0];
            2'b10:   aligned = (addr_q[1:0] == 2'b00);
            default: aligned = 1'b0;
        endcase
    end

    always_comb begin
        rdata_d = {b0, b1, b2, b3};
        case (mode_q)
            2'b00:   rdata_d = {{24{sext_q & b0[7]}}, b0};
            2'b01:   rdata_d = {{16{sext_q & b0[7]}}, b0, b1};
            default: rdata_d = {b0, b1, b2, b3};
        endcase
    end

    assign complete  = (state_q == S_WAIT) && (cnt_q == '0);
    assign wr_commit = complete && aligned && !rw_q;
    assign ld_fire   = (state_q == S_IDLE) && !mfa && ld_en;

    // Storage has no reset so contents survive a controller reset.
    always_ff @(posedge main_clk) begin
        if (wr_commit) begin
            case (mode_q)
                2'b00: mem_q[a0] <= wdata_q[7:0];
                2'b01: begin
                    mem_q[a0] <= wdata_q[15:8];
                    mem_q[a1] <= wdata_q[7:0];
                end
                default: begin
                    mem_q[a0] <= wdata_q[31:24];
                    mem_q[a1] <= wdata_q[23:16];
                    mem_q[a2] <= wdata_q[15:8];
                    mem_q[a3] <= wdata_q[7:0];
                end
            endcase
        end else if (ld_fire) begin
            mem_q[ld_addr] <= ld_data;
        end
    end

    always_ff @(posedge main_clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            rw_q    <= 1'b0;
            sext_q  <= 1'b0;
            mode_q  <= 2'b00;
            addr_q  <= '0;
            wdata_q <= '0;
            dout_q  <= '0;
            moc_q   <= 1'b0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (mfa) begin
                        rw_q    <= rw;
                        sext_q  <= sext;
                        mode_q  <= mode;
                        addr_q  <= addr;
                        wdata_q <= data_in;
                        cnt_q   <= CNT_INIT;
                        busy_q  <= 1'b1;
                        state_q <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (cnt_q == '0) begin
                        state_q <= S_DONE;
                        moc_q   <= 1'b1;
                        if (!aligned) begin
                            err_q <= 1'b1;
                        end else if (rw_q) begin
                            dout_q <= rdata_d;
                        end
                    end else begin
                        cnt_q <= cnt_q - CNT_WIDTH'(1);
                    end
                end
                S_DONE: begin
                    if (!mfa) begin
                        state_q <= S_IDLE;
                        moc_q   <= 1'b0;
                        err_q   <= 1'b0;
                        busy_q  <= 1'b0;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign data_out  = dout_q;
    assign moc       = moc_q;
    assign busy      = busy_q;
    assign align_err = err_q;

endmodule

// File: tb/tb_ram_mfa_ctrl.sv
// tb/tb_ram_mfa_ctrl.sv - scoreboard bench for ram_mfa_ctrl
module tb_ram_mfa_ctrl;

    localparam int AW = 9;

    logic          main_clk = 1'b0;
    logic          reset;
    logic          mfa, rw, sext, ld_en;
    logic [1:0]    mode;
    logic [AW-1:0] addr, ld_addr;
    logic [31:0]   data_in;
    logic [7:0]    ld_data;
    logic [31:0]   data_out;
    logic          moc, busy, align_err;

    logic          mfa1, mfa5;
    logic [31:0]   dout1, dout5;
    logic          moc1, moc5, busy1, busy5, err1, err5;

    always #5 main_clk = ~main_clk;

    ram_mfa_ctrl #(.ADDR_WIDTH(AW), .LATENCY(2), .CNT_WIDTH(4)) u_dut (
        .main_clk(main_clk), .reset(reset), .mfa(mfa), .rw(rw), .mode(mode), .sext(sext),
        .addr(addr), .data_in(data_in), .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
        .data_out(data_out), .moc(moc), .busy(busy), .align_err(align_err)
    );

    ram_mfa_ctrl #(.ADDR_WIDTH(AW), .LATENCY(1), .CNT_WIDTH(4)) u_lat1 (
        .main_clk(main_clk), .reset(reset), .mfa(mfa1), .rw(rw), .mode(mode), .sext(sext),
        .addr(addr), .data_in(data_in), .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
        .data_out(dout1), .moc(moc1), .busy(busy1), .align_err(err1)
    );

    ram_mfa_ctrl #(.ADDR_WIDTH(AW), .LATENCY(5), .CNT_WIDTH(4)) u_lat5 (
        .main_clk(main_clk), .reset(reset), .mfa(mfa5), .rw(rw), .mode(mode), .sext(sext),
        .addr(addr), .data_in(data_in), .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
        .data_out(dout5), .moc(moc5), .busy(busy5), .align_err(err5)
    );

    typedef struct {
        logic [31:0] data;
        logic        err;
        int          lat;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    int   accept_cyc = 0;
    logic moc_prev = 1'b0;

    always @(posedge main_clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    always @(negedge main_clk) begin
        if (moc && !moc_prev) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_moc: got moc=1 expected no completion");
            end else begin
                mon_e = sb_q.pop_front();
                check("data_out", data_out, mon_e.data);
                check("align_err", {31'd0, align_err}, {31'd0, mon_e.err});
                check("moc_latency", cyc - accept_cyc, mon_e.lat);
            end
        end
        moc_prev <= moc;
    end

    // Called at a negedge with the DUT idle; returns at a negedge after the handshake is released.
    task automatic req(input logic r, input logic [1:0] m, input logic s, input logic [AW-1:0] a,
                       input logic [31:0] d, input logic [31:0] exp_d, input logic exp_e,
                       input int hold);
        exp_t e;
        int   n;
        mfa = 1'b1; rw = r; mode = m; sext = s; addr = a; data_in = d;
        accept_cyc = cyc + 1;
        e.data = exp_d; e.err = exp_e; e.lat = 2;
        sb_q.push_back(e);
        @(negedge main_clk);
        ld_en = 1'b0;
        data_in = ~d;
        addr = a ^ AW'(1);
        check("busy_wait", {31'd0, busy}, 32'd1);
        n = 0;
        while (!moc && n < 40) begin
            @(negedge main_clk);
            n++;
        end
        if (!moc) begin
            checks++;
            errors++;
            $display("FAIL moc_timeout: got moc=0 expected moc=1 within 40 cycles");
        end
        repeat (hold) begin
            @(negedge main_clk);
            check("moc_hold", {31'd0, moc}, 32'd1);
            check("dout_hold", data_out, exp_d);
        end
        mfa = 1'b0;
        @(negedge main_clk);
        check("moc_release", {31'd0, moc}, 32'd0);
        check("busy_release", {31'd0, busy}, 32'd0);
    endtask

    task automatic load(input logic [AW-1:0] a, input logic [7:0] d);
        ld_en = 1'b1; ld_addr = a; ld_data = d;
        @(negedge main_clk);
        ld_en = 1'b0;
    endtask

    initial begin
        int t1, t5, start, n;
        reset = 1'b0; mfa = 1'b0; rw = 1'b0; sext = 1'b0; mode = 2'b00; addr = '0;
        data_in = '0; ld_en = 1'b0; ld_addr = '0; ld_data = '0; mfa1 = 1'b0; mfa5 = 1'b0;
        repeat (3) @(negedge main_clk);
        check("rst_moc", {31'd0, moc}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_err", {31'd0, align_err}, 32'd0);
        check("rst_dout", data_out, 32'd0);
        reset = 1'b1;
        @(negedge main_clk);

        req(1'b0, 2'b10, 1'b0, AW'(8),  32'hDEADBEEF, 32'h0000_0000, 1'b0, 0);
        req(1'b1, 2'b10, 1'b0, AW'(8),  32'h0,        32'hDEADBEEF, 1'b0, 0);
        req(1'b1, 2'b00, 1'b1, AW'(9),  32'h0,        32'hFFFFFFAD, 1'b0, 0);
        req(1'b1, 2'b00, 1'b0, AW'(9),  32'h0,        32'h000000AD, 1'b0, 0);
        req(1'b1, 2'b01, 1'b1, AW'(10), 32'h0,        32'hFFFFBEEF, 1'b0, 0);
        req(1'b1, 2'b01, 1'b0, AW'(10), 32'h0,        32'h0000BEEF, 1'b0, 0);

        req(1'b0, 2'b10, 1'b0, AW'(6),  32'h12345678, 32'h0000BEEF, 1'b1, 0);
        req(1'b1, 2'b10, 1'b0, AW'(8),  32'h0,        32'hDEADBEEF, 1'b0, 0);
        req(1'b1, 2'b01, 1'b0, AW'(3),  32'h0,        32'hDEADBEEF, 1'b1, 0);
        req(1'b1, 2'b11, 1'b0, AW'(0),  32'h0,        32'hDEADBEEF, 1'b1, 0);

        req(1'b0, 2'b10, 1'b0, AW'(16), 32'h11223344, 32'hDEADBEEF, 1'b0, 0);
        mfa = 1'b1; rw = 1'b0; mode = 2'b10; addr = AW'(16); data_in = 32'hCAFEF00D;
        @(negedge main_clk);
        check("busy_pre_reset", {31'd0, busy}, 32'd1);
        reset = 1'b0;
        #1;
        check("rst_mid_moc", {31'd0, moc}, 32'd0);
        check("rst_mid_busy", {31'd0, busy}, 32'd0);
        check("rst_mid_dout", data_out, 32'd0);
        mfa = 1'b0;
        repeat (3) @(negedge main_clk);
        reset = 1'b1;
        @(negedge main_clk);
        req(1'b1, 2'b10, 1'b0, AW'(16), 32'h0,        32'h11223344, 1'b0, 0);

        load(AW'(508), 8'h01);
        load(AW'(509), 8'h02);
        load(AW'(510), 8'h03);
        load(AW'(511), 8'h04);
        req(1'b1, 2'b10, 1'b0, AW'(508), 32'h0,       32'h01020304, 1'b0, 0);
        ld_en = 1'b1; ld_addr = AW'(508); ld_data = 8'hAA;
        req(1'b1, 2'b00, 1'b0, AW'(511), 32'h0,       32'h00000004, 1'b0, 0);
        req(1'b1, 2'b00, 1'b0, AW'(508), 32'h0,       32'h00000001, 1'b0, 0);

        req(1'b0, 2'b01, 1'b0, AW'(100), 32'h0000A5C3, 32'h00000001, 1'b0, 5);
        req(1'b1, 2'b01, 1'b0, AW'(100), 32'h0,        32'h0000A5C3, 1'b0, 0);
        req(1'b0, 2'b00, 1'b0, AW'(101), 32'h000000FF, 32'h0000A5C3, 1'b0, 0);
        req(1'b1, 2'b01, 1'b1, AW'(100), 32'h0,        32'hFFFFA5FF, 1'b0, 0);

        rw = 1'b0; mode = 2'b10; addr = AW'(0); data_in = 32'h0BADF00D;
        mfa1 = 1'b1; mfa5 = 1'b1;
        start = cyc + 1; t1 = -1; t5 = -1;
        for (int i = 0; i < 20; i++) begin
            @(negedge main_clk);
            if (moc1 && t1 < 0) t1 = cyc - start;
            if (moc5 && t5 < 0) t5 = cyc - start;
        end
        check("lat1_moc_edge", t1, 32'd1);
        check("lat5_moc_edge", t5, 32'd5);
        check("lat1_moc_held", {31'd0, moc1}, 32'd1);
        mfa1 = 1'b0; mfa5 = 1'b0;
        @(negedge main_clk);
        check("lat1_release", {31'd0, moc1}, 32'd0);
        check("lat5_release", {31'd0, moc5}, 32'd0);
        rw = 1'b1;
        mfa5 = 1'b1;
        n = 0;
        @(negedge main_clk);
        while (!moc5 && n < 40) begin
            @(negedge main_clk);
            n++;
        end
        check("lat5_read", dout5, 32'h0BADF00D);
        mfa5 = 1'b0;
        @(negedge main_clk);

        n = 0;
        while (sb_q.size() != 0 && n < 50) begin
            @(negedge main_clk);
            n++;
        end
        if (sb_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
